// File: rtl/sdram_init_pkg.sv
// Shared types and constants for the SDRAM power-up initialization sequencer.
// Optional refresh timer in the top is enabled by SDR_INIT_REFRESH_TIMER_EN.
package sdram_init_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        PRECHARGE,
        TRP_WAIT,
        AREF,
        TRFC_WAIT,
        LMR,
        TMRD_WAIT,
        DONE
    } init_state_e;

    // Command encodings as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE  = 4'b0011;
    localparam logic [3:0] CMD_AREF    = 4'b0001;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    // Mode register field offsets
    localparam int MR_BL_LSB  = 0;
    localparam int MR_BT_BIT  = 3;
    localparam int MR_CAS_LSB = 4;
    localparam int MR_OP_LSB  = 7;
    localparam int MR_WB_BIT  = 9;
    localparam int A10_BIT    = 10;

    // Only CL2 and CL3 are supported; anything else falls back to the safe CL3.
    function automatic logic [2:0] cas_code(input logic [2:0] cas);
        logic [2:0] code;
        if (cas == 3'd2) begin
            code = 3'd2;
        end else begin
            code = 3'd3;
        end
        return code;
    endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module sdram_init_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Counter register: load has priority over decrement
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: NOP hold, PRECHARGE ALL, NUM_AR AUTO REFRESH, LOAD MODE.
// Define SDR_INIT_REFRESH_TIMER_EN to add the periodic refresh request timer.
module sdram_init_seq
    import sdram_init_pkg::*;
#(
    parameter int INIT_NOP_CYCLES = 10000,
    parameter int PRE_GAP         = 3,
    parameter int TRP             = 8,
    parameter int TRFC            = 10,
    parameter int NUM_AR          = 16,
    parameter int TMRD            = 18,
    parameter int SDR_AW          = 13,
    parameter int REF_INTERVAL    = 780
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [2:0]        cfg_sdr_cas,
    input  logic [2:0]        cfg_burst_len,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [1:0]        sdr_ba,
    output logic [SDR_AW-1:0] sdr_addr,
    output logic              init_done,
    output logic              ref_req,
    input  logic              ref_ack
);

    localparam int P_CYC = INIT_NOP_CYCLES + PRE_GAP;
    localparam int MAX_A = (P_CYC > TRP) ? P_CYC : TRP;
    localparam int MAX_B = (MAX_A > TRFC) ? MAX_A : TRFC;
    localparam int MAX_C = (MAX_B > TMRD) ? MAX_B : TMRD;
    localparam int MAX_D = (MAX_C > REF_INTERVAL) ? MAX_C : REF_INTERVAL;
    localparam int CNT_W = $clog2(MAX_D + 1);

    // Delays are loaded on the edge that issues the preceding command
    localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(P_CYC - 1);
    localparam logic [CNT_W-1:0] LD_TRP  = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] LD_TRFC = CNT_W'(TRFC - 1);
    localparam logic [CNT_W-1:0] LD_TMRD = CNT_W'(TMRD - 1);
    localparam logic [7:0]       NUM_AR_C = 8'(NUM_AR);

    init_state_e        state_r, state_s;
    logic               started_r, started_s;
    logic [7:0]         ar_cnt_r, ar_cnt_s;
    logic [3:0]         cmd_r, cmd_s;
    logic [SDR_AW-1:0]  addr_r, addr_s;
    logic [1:0]         ba_r;
    logic               init_done_r;
    logic               tmr_load_s;
    logic [CNT_W-1:0]   tmr_val_s;
    logic               tmr_zero_s;

    sdram_init_timer #(.W(CNT_W)) u_wait_tmr (
        .clk      (sys_clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Next-state, next-command and wait-timer control
    always_comb begin
        state_s    = state_r;
        started_s  = started_r;
        ar_cnt_s   = ar_cnt_r;
        tmr_load_s = 1'b0;
        tmr_val_s  = {CNT_W{1'b0}};
        cmd_s      = CMD_NOP;
        addr_s     = {SDR_AW{1'b0}};
        case (state_r)
            PWR_WAIT: begin
                if (!started_r) begin
                    started_s  = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_PWR;
                    cmd_s      = CMD_INHIBIT;
                end else if (tmr_zero_s) begin
                    state_s         = PRECHARGE;
                    tmr_load_s      = 1'b1;
                    tmr_val_s       = LD_TRP;
                    cmd_s           = CMD_PRE;
                    addr_s[A10_BIT] = 1'b1;
                end else begin
                    state_s = PWR_WAIT;
                end
            end
            PRECHARGE: state_s = TRP_WAIT;
            TRP_WAIT: begin
                if (tmr_zero_s) begin
                    state_s    = AREF;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_TRFC;
                    cmd_s      = CMD_AREF;
                    ar_cnt_s   = ar_cnt_r + 8'd1;
                end else begin
                    state_s = TRP_WAIT;
                end
            end
            AREF: state_s = TRFC_WAIT;
            TRFC_WAIT: begin
                if (tmr_zero_s && (ar_cnt_r < NUM_AR_C)) begin
                    state_s    = AREF;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_TRFC;
                    cmd_s      = CMD_AREF;
                    ar_cnt_s   = ar_cnt_r + 8'd1;
                end else if (tmr_zero_s) begin
                    state_s    = LMR;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_TMRD;
                    cmd_s      = CMD_LMR;
                    addr_s[MR_BL_LSB +: 3]  = cfg_burst_len;
                    addr_s[MR_CAS_LSB +: 3] = cas_code(cfg_sdr_cas);
                end else begin
                    state_s = TRFC_WAIT;
                end
            end
            LMR: state_s = TMRD_WAIT;
            TMRD_WAIT: begin
                if (tmr_zero_s) begin
                    state_s = DONE;
                end else begin
                    state_s = TMRD_WAIT;
                end
            end
            DONE:    state_s = DONE;
            default: state_s = PWR_WAIT;
        endcase
    end

    // State, counters and registered pin outputs
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_r     <= PWR_WAIT;
            started_r   <= 1'b0;
            ar_cnt_r    <= 8'd0;
            cmd_r       <= CMD_INHIBIT;
            addr_r      <= {SDR_AW{1'b0}};
            ba_r        <= 2'b00;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            started_r   <= started_s;
            ar_cnt_r    <= ar_cnt_s;
            cmd_r       <= cmd_s;
            addr_r      <= addr_s;
            ba_r        <= 2'b00;
            init_done_r <= (state_s == DONE);
        end
    end

    assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_r;
    assign sdr_addr  = addr_r;
    assign sdr_ba    = ba_r;
    assign init_done = init_done_r;

`ifdef SDR_INIT_REFRESH_TIMER_EN
    localparam logic [CNT_W-1:0] LD_REF = CNT_W'(REF_INTERVAL - 1);

    logic ref_load_s;
    logic ref_zero_s;
    logic ref_expire_s;
    logic ref_req_r;

    assign ref_expire_s = init_done_r && ref_zero_s;
    assign ref_load_s   = ((state_r == TMRD_WAIT) && (state_s == DONE)) || ref_expire_s;

    sdram_init_timer #(.W(CNT_W)) u_ref_tmr (
        .clk      (sys_clk),
        .reset    (reset),
        .load     (ref_load_s),
        .load_val (LD_REF),
        .zero     (ref_zero_s)
    );

    // A new expiry wins over a coincident acknowledge
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ref_req_r <= 1'b0;
        end else if (ref_expire_s) begin
            ref_req_r <= 1'b1;
        end else if (ref_ack) begin
            ref_req_r <= 1'b0;
        end else begin
            ref_req_r <= ref_req_r;
        end
    end

    assign ref_req = ref_req_r;
`else
    logic unused_ref_ack_s;
    assign unused_ref_ack_s = ref_ack;
    assign ref_req = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_init_seq.sv
// Self-checking bench for sdram_init_seq: full sequences with random mode settings,
// mid-sequence reset, and refresh-request behaviour (SDR_INIT_REFRESH_TIMER_EN aware).
module tb_sdram_init_seq;

    localparam int INIT_NOP = 10000;
    localparam int PRE_GAP  = 3;
    localparam int TRP      = 8;
    localparam int TRFC     = 10;
    localparam int NUM_AR   = 16;
    localparam int TMRD     = 18;
    localparam int AW       = 13;
    localparam int REF_INT  = 50;

    localparam int P  = INIT_NOP + PRE_GAP;
    localparam int L  = P + TRP + NUM_AR * TRFC;
    localparam int D  = L + TMRD;

    localparam logic [3:0] C_INH  = 4'b1111;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_LMR  = 4'b0000;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    cfg_sdr_cas = 3'd2;
    logic [2:0]    cfg_burst_len = 3'd0;
    logic          sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [1:0]    sdr_ba;
    logic [AW-1:0] sdr_addr;
    logic          init_done;
    logic          ref_req;
    logic          ref_ack = 1'b0;

    int total = 0;
    int bad   = 0;
    int cur_n = 0;
    logic req_exp = 1'b0;

    sdram_init_seq #(
        .INIT_NOP_CYCLES (INIT_NOP),
        .PRE_GAP         (PRE_GAP),
        .TRP             (TRP),
        .TRFC            (TRFC),
        .NUM_AR          (NUM_AR),
        .TMRD            (TMRD),
        .SDR_AW          (AW),
        .REF_INTERVAL    (REF_INT)
    ) dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .cfg_sdr_cas   (cfg_sdr_cas),
        .cfg_burst_len (cfg_burst_len),
        .sdr_cs_n      (sdr_cs_n),
        .sdr_ras_n     (sdr_ras_n),
        .sdr_cas_n     (sdr_cas_n),
        .sdr_we_n      (sdr_we_n),
        .sdr_ba        (sdr_ba),
        .sdr_addr      (sdr_addr),
        .init_done     (init_done),
        .ref_req       (ref_req),
        .ref_ack       (ref_ack)
    );

    always #5 sys_clk = ~sys_clk;

    // Command expected on the pins at cycle n, straight from the schedule formulas.
    function automatic logic [3:0] exp_cmd(input int n);
        if (n == 0) return C_INH;
        if (n == P) return C_PRE;
        if (n >= P + TRP && n < L && ((n - P - TRP) % TRFC) == 0) return C_AREF;
        if (n == L) return C_LMR;
        return C_NOP;
    endfunction

    function automatic logic [AW-1:0] exp_mode(input logic [2:0] cas, input logic [2:0] bl);
        logic [AW-1:0] m;
        logic [2:0] cl;
        cl = (cas == 3'd2) ? 3'd2 : 3'd3;
        m = {AW{1'b0}};
        m[2:0] = bl;
        m[6:4] = cl;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cur_n, obs, expv);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cmd"}, {28'd0, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, {28'd0, C_INH});
        chk({tag, "_addr"}, {19'd0, sdr_addr}, 32'd0);
        chk({tag, "_ba"}, {30'd0, sdr_ba}, 32'd0);
        chk({tag, "_done"}, {31'd0, init_done}, 32'd0);
        chk({tag, "_req"}, {31'd0, ref_req}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ref_ack = 1'b0;
        cur_n = -1;
        repeat (3) @(posedge sys_clk);
        #1;
        req_exp = 1'b0;
        chk_reset_state("reset");
        reset = 1'b0;
    endtask

    // One power-up run; abort_at >= 0 asserts reset the cycle after that command.
    task automatic run_seq(input logic [2:0] cas, input logic [2:0] bl, input bit toggle,
                           input int abort_at, input int tail);
        logic expiry;
        logic ack_now;
        do_reset();
        for (int n = 0; n <= D + tail; n++) begin
            cur_n = n;
            if (abort_at >= 0 && n == abort_at + 1) begin
                reset = 1'b1;
                @(posedge sys_clk);
                #1;
                req_exp = 1'b0;
                chk_reset_state("mid_reset");
                return;
            end
            cfg_burst_len = bl;
            if (n == L || !toggle) cfg_sdr_cas = cas;
            else cfg_sdr_cas = 3'($urandom_range(7, 0));
            ack_now = ($urandom_range(3, 0) == 0) || (n == D + 2 * REF_INT);
            ref_ack = ack_now;
            @(posedge sys_clk);
            #1;
`ifdef SDR_INIT_REFRESH_TIMER_EN
            expiry = (n > D) && (((n - D) % REF_INT) == 0);
            if (expiry) req_exp = 1'b1;
            else if (ack_now) req_exp = 1'b0;
`else
            expiry = 1'b0;
            req_exp = expiry;
`endif
            chk("cmd", {28'd0, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, {28'd0, exp_cmd(n)});
            chk("init_done", {31'd0, init_done}, {31'd0, (n >= D)});
            chk("ref_req", {31'd0, ref_req}, {31'd0, req_exp});
            if (n == P) chk("pre_a10", {31'd0, sdr_addr[10]}, 32'd1);
            if (n == L) begin
                chk("lmr_addr", {19'd0, sdr_addr}, {19'd0, exp_mode(cas, bl)});
                chk("lmr_ba", {30'd0, sdr_ba}, 32'd0);
            end
        end
    endtask

    initial begin
        // Defaults, CL2, burst code 0: mode word 13'h0020
        run_seq(3'd2, 3'd0, 1'b0, -1, 5);
        // CL3 with CAS input scrambled everywhere except the LMR cycle
        run_seq(3'd3, 3'($urandom_range(7, 0)), 1'b1, -1, 5);
        // Illegal CL coerced to 3
        run_seq(3'd5, 3'($urandom_range(7, 0)), 1'b1, -1, 5);
        // Reset on the third AUTO REFRESH, then a full restart
        run_seq(3'd2, 3'd1, 1'b0, P + TRP + 2 * TRFC, 5);
        // Random CAS code, then a long stretch in DONE with random acknowledges
        run_seq(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 1'b1, -1, 1000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
- Power-up initialization sequencer for the SDRAM controller.
- Drives the SDRAM command pins from reset until the device is programmed, in this order: COMMAND INHIBIT/NOP hold, PRECHARGE ALL, NUM_AR AUTO REFRESH cycles, LOAD MODE REGISTER.
- Asserts init_done when the sequence completes; the controller's command arbiter then takes over the pins.
- Sits directly upstream of the SDRAM pin mux. Its command stream is what the team's initialization assertions check.

Parameters:
- INIT_NOP_CYCLES, 10000, NOP cycles after reset release (100 us at 100 MHz).
- PRE_GAP, 3, additional NOP cycles before PRECHARGE.
- TRP, 8, cycles from PRECHARGE to first AUTO REFRESH.
- TRFC, 10, cycles between consecutive AUTO REFRESH commands, and from last AUTO REFRESH to LOAD MODE REGISTER.
- NUM_AR, 16, number of AUTO REFRESH commands (legal range 2..255).
- TMRD, 18, cycles from LOAD MODE REGISTER to init_done.
- SDR_AW, 13, SDRAM address width.
- REF_INTERVAL, 780, refresh period in cycles (used only with the optional feature).

Ports:
- sys_clk  in  1  controller clock.
- reset  in  1  synchronous, active-high.
- cfg_sdr_cas  in  3  CAS latency; legal values 2 and 3.
- cfg_burst_len  in  3  mode register burst-length code.
- sdr_cs_n  out  1  chip select, active low.
- sdr_ras_n  out  1  row address strobe, active low.
- sdr_cas_n  out  1  column address strobe, active low.
- sdr_we_n  out  1  write enable, active low.
- sdr_ba  out  2  bank address.
- sdr_addr  out  SDR_AW  address bus.
- init_done  out  1  level; high once initialization is complete.
- ref_req  out  1  periodic refresh request (optional feature).
- ref_ack  in  1  arbiter has issued the requested refresh.

Behaviour:
- Reset (synchronous, sampled on a sys_clk edge):
  - Outputs registered to COMMAND INHIBIT: cs_n=ras_n=cas_n=we_n=1, sdr_addr=0, sdr_ba=0.
  - init_done=0, ref_req=0.
  - FSM to PWR_WAIT, counters cleared.
- Cycle numbering: cycle 0 is the first edge at which reset is sampled low. All commands below are registered and hold for exactly one cycle. Between commands the outputs drive NOP (cs_n=0, ras/cas/we=1).
- Command sequence:
  - Cycles 0 .. INIT_NOP_CYCLES+PRE_GAP-1: INHIBIT/NOP. Cycle 0 output is INHIBIT; all later cycles are NOP.
  - Cycle P = INIT_NOP_CYCLES+PRE_GAP: PRECHARGE (0,0,1,0) with sdr_addr[10]=1 (all banks).
  - AUTO REFRESH k (k = 0..NUM_AR-1), encoding (0,0,0,1), at cycle P+TRP+k*TRFC.
  - LOAD MODE REGISTER (0,0,0,0) at cycle L = P+TRP+NUM_AR*TRFC, with sdr_ba=0.
  - Mode register addr contents: addr[2:0]=cfg_burst_len, addr[3]=0 (sequential), addr[6:4]=CAS, addr[8:7]=0, addr[9]=0, upper bits=0.
  - init_done rises at cycle L+TMRD and remains high until reset.
- FSM states: PWR_WAIT → PRECHARGE → TRP_WAIT → AREF → TRFC_WAIT (loops to AREF while refresh count < NUM_AR) → LMR → TMRD_WAIT → DONE.
- Each wait state loads the shared down-counter with (delay−1) and exits when it reaches 0.
- CAS handling:
  - cfg_sdr_cas is sampled only in the LMR cycle; changes at any other time have no effect.
  - Values other than 2 and 3 are coerced to 3.
- Widths:
  - Delay counter width: $clog2(max(INIT_NOP_CYCLES+PRE_GAP, TRP, TRFC, TMRD, REF_INTERVAL)+1).
  - Refresh counter width: 8 bits.
- Reset mid-sequence, including in DONE: same-cycle transition to the reset state, then a full restart. No partial resume.
- In DONE, the pin outputs drive NOP; the external mux selects the arbiter using init_done.

Optional Feature:
- Macro: SDR_INIT_REFRESH_TIMER_EN.
- When defined:
  - In DONE, a counter loads REF_INTERVAL−1 when init_done rises and decrements each cycle.
  - At 0, ref_req is set and the counter reloads.
  - ref_req stays high until ref_ack is sampled high; it clears the following cycle.
  - If ref_ack and expiry coincide, ref_req stays high (the new request wins).
- When undefined: ref_req is tied to 0, ref_ack is ignored, and no timer logic is present.

Decomposition:
- Package sdram_init_pkg holds:
  - the state enum;
  - 4-bit command constants {cs_n,ras_n,cas_n,we_n}: CMD_INHIBIT=4'b1111, CMD_NOP=4'b0111, CMD_ACTIVE=4'b0011, CMD_AREF=4'b0001, CMD_PRE=4'b0010, CMD_LMR=4'b0000;
  - mode-register field offsets.
- One sub-module, sdram_init_timer: loadable down-counter with load value, load strobe and zero flag. It is shared across the FSM wait states and instantiated a second time for the optional refresh timer.

Test Plan:
- Full sequence, defaults, CAS=2: PRECHARGE at cycle 10003; AUTO REFRESH at 10011, 10021, …, 10161; LMR at 10171 with sdr_addr=13'h0020 when cfg_burst_len=0; init_done rises at cycle 10189. No other commands appear.
- Small parameters (INIT_NOP_CYCLES=20, NUM_AR=2, TRFC=4), CAS=3: LMR with addr[6:4]=3; cfg_sdr_cas toggled outside the LMR cycle has no effect.
- cfg_sdr_cas=5: LMR addr[6:4]=3.
- Reset asserted at cycle of third AUTO REFRESH: next cycle outputs INHIBIT, init_done=0; sequence restarts with PRECHARGE at cycle P after release.
- With SDR_INIT_REFRESH_TIMER_EN and REF_INTERVAL=50: ref_req rises 50 cycles after init_done; it holds until ref_ack; with ref_ack asserted the same cycle as the next expiry, ref_req remains 1.
- Macro undefined: ref_req stays 0 through init and 1000 cycles of DONE regardless of ref_ack.
